// File: rtl/chip8_stack_ctrl_if.sv
// Stack-op encoding shared with Chip8_Stack, plus the CPU/stack-facing bundle of chip8_stack_ctrl.
// The slave modport is the controller; the master modport is the decode stage together with the stack.
package chip8_stack_pkg;
  typedef enum logic [1:0] {
    STACK_HOLD = 2'd0,
    STACK_PUSH = 2'd1,
    STACK_POP  = 2'd2
  } stack_op_e;
endpackage

interface chip8_stack_ctrl_if #(
  parameter int DEPTH = 16
);
  localparam int DW = $clog2(DEPTH + 1);

  logic                       call_req;
  logic                       ret_req;
  logic [11:0]                call_addr;
  logic [15:0]                pc;
  logic                       clear_err;
  chip8_stack_pkg::stack_op_e stk_op;
  logic [15:0]                stk_writedata;
  logic [15:0]                stk_outdata;
  logic                       busy;
  logic                       done;
  logic                       err;
  logic [15:0]                new_pc;
  logic [DW-1:0]              depth;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output call_req, ret_req, call_addr, pc, clear_err, stk_outdata,
    input  stk_op, stk_writedata, busy, done, err, new_pc, depth, overflow, underflow
  );

  modport slave (
    input  call_req, ret_req, call_addr, pc, clear_err, stk_outdata,
    output stk_op, stk_writedata, busy, done, err, new_pc, depth, overflow, underflow
  );
endinterface

// File: rtl/chip8_stack_ctrl.sv
// Sequences Chip8_Stack PUSH/POP for CALL (2nnn) and RET (00EE), returning the next PC with a done pulse.
// Keeps its own depth count so full/empty requests are refused without touching the stack.
module chip8_stack_ctrl
  import chip8_stack_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1
) (
  input logic               cpu_clk,
  input logic               reset,
  chip8_stack_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic          is_call_q;
  logic [15:0]   target_q;
  stack_op_e     stk_op_q;
  logic [15:0]   stk_writedata_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          pop_done_q;
  logic [15:0]   new_pc_q;
  logic [DW-1:0] depth_q;
  logic          overflow_q;
  logic          underflow_q;

  // All outputs are registered alongside the state; done/err/stk_op default to idle values each cycle.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      is_call_q       <= 1'b0;
      target_q        <= '0;
      stk_op_q        <= STACK_HOLD;
      stk_writedata_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      pop_done_q      <= 1'b0;
      new_pc_q        <= 16'h0200;
      depth_q         <= '0;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      stk_op_q   <= STACK_HOLD;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pop_done_q <= 1'b0;
      // Later flag sets in this block override the clear, so set wins.
      if (bus.clear_err) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (bus.call_req) begin
            busy_q    <= 1'b1;
            is_call_q <= 1'b1;
            if (depth_q == DW'(DEPTH)) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              overflow_q <= 1'b1;
            end else begin
              state_q         <= S_PUSH;
              stk_op_q        <= STACK_PUSH;
              stk_writedata_q <= bus.pc + 16'd2;
              target_q        <= {4'h0, bus.call_addr};
            end
          end else if (bus.ret_req) begin
            busy_q    <= 1'b1;
            is_call_q <= 1'b0;
            if (depth_q == '0) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              err_q       <= 1'b1;
              underflow_q <= 1'b1;
            end else begin
              state_q  <= S_POP;
              stk_op_q <= STACK_POP;
            end
          end
        end
        S_PUSH, S_POP: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          if (cnt_q == 3'(SETTLE - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            if (is_call_q) new_pc_q <= target_q;
            else           pop_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!err_q) begin
            if (is_call_q) depth_q <= depth_q + DW'(1);
            else           depth_q <= depth_q - DW'(1);
          end
          if (pop_done_q) new_pc_q <= bus.stk_outdata;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A popped return address only settles during DONE itself, so it bypasses new_pc_q for that cycle.
  assign bus.new_pc        = pop_done_q ? bus.stk_outdata : new_pc_q;
  assign bus.stk_op        = stk_op_q;
  assign bus.stk_writedata = stk_writedata_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.depth         = depth_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;

endmodule

// File: tb/tb_chip8_stack_ctrl.sv
// Bench for chip8_stack_ctrl: a behavioural stack device, a transaction-timeline reference model
// checked every cycle, directed scenarios with literal expectations, then a randomized request stream.
module tb_chip8_stack_ctrl;
  import chip8_stack_pkg::*;

  localparam int DEPTH  = 16;
  localparam int SETTLE = 1;

  logic cpu_clk = 1'b0;
  logic reset   = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  chip8_stack_ctrl_if #(.DEPTH(DEPTH)) bus();

  chip8_stack_ctrl #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stack device: output shows junk until SETTLE cycles after a POP have passed.
  logic [15:0] devQ[$];
  int          opCount   = 0;
  int          settleCnt = 0;
  logic [15:0] pendVal   = '0;

  always @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      devQ.delete();
      settleCnt = 0;
      bus.stk_outdata <= 16'h0000;
    end else begin
      if (settleCnt > 0) begin
        settleCnt--;
        if (settleCnt == 0) bus.stk_outdata <= pendVal;
      end
      if (bus.stk_op == STACK_PUSH) begin
        opCount++;
        if (devQ.size() < DEPTH) devQ.push_back(bus.stk_writedata);
      end else if (bus.stk_op == STACK_POP) begin
        opCount++;
        if (devQ.size() > 0) pendVal = devQ.pop_back();
        else                 pendVal = 16'h0BAD;
        bus.stk_outdata <= ~pendVal;
        settleCnt = SETTLE;
      end
    end
  end

  // Reference model: each accepted request is a window of cycles [accCyc+1, doneCyc].
  int          cyc     = 0;
  bit          active  = 1'b0;
  bit          isErr   = 1'b0;
  bit          isCall  = 1'b0;
  int          accCyc  = 0;
  int          doneCyc = 0;
  int          mDepth  = 0;
  bit          mOvf    = 1'b0;
  bit          mUdf    = 1'b0;
  logic [15:0] mNewPc  = 16'h0200;
  logic [15:0] mResult = '0;
  logic [15:0] mWd     = '0;
  logic [15:0] mStack[$];

  always @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      active = 1'b0;
      mDepth = 0;
      mOvf   = 1'b0;
      mUdf   = 1'b0;
      mNewPc = 16'h0200;
      mWd    = '0;
      mStack.delete();
    end else begin
      if (bus.clear_err) begin
        mOvf = 1'b0;
        mUdf = 1'b0;
      end
      if (active) begin
        if (cyc == doneCyc) begin
          if (!isErr) begin
            mNewPc = mResult;
            mDepth += isCall ? 1 : -1;
          end
          active = 1'b0;
        end
      end else if (bus.call_req || bus.ret_req) begin
        active = 1'b1;
        accCyc = cyc;
        isCall = bus.call_req;
        if (isCall && mDepth == DEPTH) begin
          isErr = 1'b1; doneCyc = cyc + 1; mOvf = 1'b1;
        end else if (!isCall && mDepth == 0) begin
          isErr = 1'b1; doneCyc = cyc + 1; mUdf = 1'b1;
        end else begin
          isErr   = 1'b0;
          doneCyc = cyc + 2 + SETTLE;
          if (isCall) begin
            mWd = bus.pc + 16'd2;
            mStack.push_back(mWd);
            mResult = {4'h0, bus.call_addr};
          end else begin
            mResult = mStack.pop_back();
          end
        end
      end
      cyc++;
    end
  end

  always @(negedge cpu_clk) begin
    if (!reset) begin
      bit        expDone;
      stack_op_e expOp;
      expDone = active && (cyc == doneCyc);
      expOp   = STACK_HOLD;
      if (active && !isErr && cyc == accCyc + 1) expOp = isCall ? STACK_PUSH : STACK_POP;
      checkOutput("busy", 32'(bus.busy), 32'(active));
      checkOutput("done", 32'(bus.done), 32'(expDone));
      checkOutput("err", 32'(bus.err), 32'(expDone && isErr));
      checkOutput("stk_op", 32'(bus.stk_op), 32'(expOp));
      checkOutput("stk_writedata", 32'(bus.stk_writedata), 32'(mWd));
      checkOutput("new_pc", 32'(bus.new_pc), 32'((expDone && !isErr) ? mResult : mNewPc));
      checkOutput("depth", 32'(bus.depth), 32'(mDepth));
      checkOutput("overflow", 32'(bus.overflow), 32'(mOvf));
      checkOutput("underflow", 32'(bus.underflow), 32'(mUdf));
    end
  end

  task automatic applyReset();
    reset         = 1'b1;
    bus.call_req  = 1'b0;
    bus.ret_req   = 1'b0;
    bus.clear_err = 1'b0;
    repeat (2) @(posedge cpu_clk);
    #1;
    reset = 1'b0;
  endtask

  // Issues one request and waits (bounded) for done; pokeRet pulses ret_req while busy.
  task automatic applyStimulus(input bit c, input bit r, input logic [15:0] p, input logic [11:0] a,
                               input bit pokeRet, output logic [15:0] npc, output bit e,
                               output int lat, output stack_op_e opT1, output logic [15:0] wdT1);
    bus.call_req  = c;
    bus.ret_req   = r;
    bus.pc        = p;
    bus.call_addr = a;
    @(posedge cpu_clk);
    #1;
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    lat  = 0;
    npc  = '0;
    e    = 1'b0;
    opT1 = STACK_HOLD;
    wdT1 = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge cpu_clk);
      if (i == 0) begin
        opT1 = bus.stk_op;
        wdT1 = bus.stk_writedata;
      end
      bus.ret_req = (i == 0) ? pokeRet : 1'b0;
      if (bus.done) begin
        lat = i + 1;
        npc = bus.new_pc;
        e   = bus.err;
        break;
      end
    end
    bus.ret_req = 1'b0;
    if (lat == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got no done within 16 cycles expected done");
    end
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    logic [15:0] npc;
    bit          e;
    int          lat;
    stack_op_e   o;
    logic [15:0] wd;
    int          ops;
    logic [15:0] pcs[4];
    logic [15:0] rets[4];
    pcs  = '{16'hEFFE, 16'h0EFE, 16'h00EE, 16'h000D};
    rets = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
    bus.call_req  = 1'b0;
    bus.ret_req   = 1'b0;
    bus.clear_err = 1'b0;
    bus.pc        = '0;
    bus.call_addr = '0;

    applyReset();
    @(negedge cpu_clk);
    checkOutput("rst_new_pc", 32'(bus.new_pc), 32'h0200);
    checkOutput("rst_depth", 32'(bus.depth), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_stk_op", 32'(bus.stk_op), 32'(STACK_HOLD));
    checkOutput("rst_wd", 32'(bus.stk_writedata), 0);
    @(posedge cpu_clk);
    #1;

    applyStimulus(1'b1, 1'b0, 16'h0300, 12'hABC, 1'b0, npc, e, lat, o, wd);
    checkOutput("call_op_t1", 32'(o), 32'(STACK_PUSH));
    checkOutput("call_wd_t1", 32'(wd), 32'h0302);
    checkOutput("call_latency", 32'(lat), 3);
    checkOutput("call_new_pc", 32'(npc), 32'h0ABC);
    checkOutput("call_err", 32'(e), 0);
    checkOutput("call_depth", 32'(bus.depth), 1);

    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, pcs[i], 12'(i), 1'b0, npc, e, lat, o, wd);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0, 12'h0, 1'b0, npc, e, lat, o, wd);
      checkOutput($sformatf("ret_new_pc%0d", i), 32'(npc), 32'(rets[i]));
    end
    checkOutput("ret_depth_end", 32'(bus.depth), 0);

    applyReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 16'($urandom), 12'(12'h100 + i), 1'b0, npc, e, lat, o, wd);
    ops = opCount;
    applyStimulus(1'b1, 1'b0, 16'h1234, 12'h555, 1'b0, npc, e, lat, o, wd);
    checkOutput("ovf_latency", 32'(lat), 1);
    checkOutput("ovf_err", 32'(e), 1);
    checkOutput("ovf_new_pc", 32'(npc), 32'h010F);
    checkOutput("ovf_no_push", 32'(opCount), 32'(ops));
    checkOutput("ovf_flag", 32'(bus.overflow), 1);
    checkOutput("ovf_depth", 32'(bus.depth), 16);
    bus.clear_err = 1'b1;
    @(posedge cpu_clk);
    #1;
    bus.clear_err = 1'b0;
    checkOutput("ovf_cleared", 32'(bus.overflow), 0);

    applyReset();
    ops = opCount;
    applyStimulus(1'b0, 1'b1, 16'h0, 12'h0, 1'b0, npc, e, lat, o, wd);
    checkOutput("udf_latency", 32'(lat), 1);
    checkOutput("udf_err", 32'(e), 1);
    checkOutput("udf_new_pc", 32'(npc), 32'h0200);
    checkOutput("udf_no_pop", 32'(opCount), 32'(ops));
    checkOutput("udf_flag", 32'(bus.underflow), 1);

    applyReset();
    applyStimulus(1'b1, 1'b0, 16'h0400, 12'h222, 1'b0, npc, e, lat, o, wd);
    applyStimulus(1'b1, 1'b1, 16'h0500, 12'h333, 1'b1, npc, e, lat, o, wd);
    checkOutput("both_op_t1", 32'(o), 32'(STACK_PUSH));
    checkOutput("both_wd_t1", 32'(wd), 32'h0502);
    checkOutput("both_new_pc", 32'(npc), 32'h0333);
    checkOutput("both_depth", 32'(bus.depth), 2);
    checkOutput("busy_ret_ignored", 32'(bus.busy), 0);

    applyReset();
    applyStimulus(1'b1, 1'b0, 16'h0600, 12'h444, 1'b0, npc, e, lat, o, wd);
    bus.call_req  = 1'b1;
    bus.pc        = 16'h0700;
    bus.call_addr = 12'h555;
    @(posedge cpu_clk);
    #1;
    bus.call_req = 1'b0;
    @(posedge cpu_clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rstw_stk_op", 32'(bus.stk_op), 32'(STACK_HOLD));
    checkOutput("rstw_busy", 32'(bus.busy), 0);
    checkOutput("rstw_depth", 32'(bus.depth), 0);
    checkOutput("rstw_new_pc", 32'(bus.new_pc), 32'h0200);
    @(posedge cpu_clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge cpu_clk);
      checkOutput("rstw_no_done", 32'(bus.done), 0);
    end
    @(posedge cpu_clk);
    #1;

    applyReset();
    for (int i = 0; i < 800; i++) begin
      bus.call_req  = ($urandom_range(0, 99) < 35);
      bus.ret_req   = ($urandom_range(0, 99) < 30);
      bus.clear_err = ($urandom_range(0, 99) < 5);
      bus.pc        = 16'($urandom);
      bus.call_addr = 12'($urandom);
      @(posedge cpu_clk);
      #1;
    end
    bus.call_req  = 1'b0;
    bus.ret_req   = 1'b0;
    bus.clear_err = 1'b0;
    repeat (8) @(posedge cpu_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
